// File: rtl/pifo_reg_pkg.sv
// Shared constants and types for the register-based PIFO controller.
package pifo_reg_pkg;

  localparam int REG_WIDTH  = 16;
  localparam int IDX_WIDTH  = 4;
  localparam int DATA_WIDTH = 16;
  localparam int META_WIDTH = 32;

  // One storage slot of the PIFO.
  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] rank;
    logic [META_WIDTH-1:0] meta;
  } slot_t;

  // Comparator tree node: metadata stays in the slots and is fetched by idx.
  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] rank;
    logic [IDX_WIDTH-1:0]  idx;
  } node_t;

  typedef enum logic {
    READY  = 1'b0,
    SETTLE = 1'b1
  } state_e;

  // Pairwise min stage. The left operand carries the lower indices, so it
  // wins ties; a lone valid operand always wins.
  function automatic node_t node_min(input node_t a, input node_t b);
    if (!b.vld || (a.vld && (a.rank <= b.rank))) return a;
    return b;
  endfunction

endpackage

// File: rtl/pifo_min_tree.sv
// log2(N)-level pairwise-min tree over {vld, rank, idx}; purely combinational.
module pifo_min_tree
  import pifo_reg_pkg::*;
#(
  parameter int N    = REG_WIDTH,
  parameter int LVLS = IDX_WIDTH
) (
  input  node_t [N-1:0] leaf,
  output node_t         root
);

  for (genvar l = 0; l < LVLS; l++) begin : lvl_g
    localparam int NN = N >> (l + 1);
    node_t [NN-1:0] y;
    for (genvar n = 0; n < NN; n++) begin : node_g
      if (l == 0) begin : leaf_g
        assign y[n] = node_min(leaf[2*n], leaf[2*n+1]);
      end else begin : inner_g
        assign y[n] = node_min(lvl_g[l-1].y[2*n], lvl_g[l-1].y[2*n+1]);
      end
    end
  end

  assign root = lvl_g[LVLS-1].y[0];

endmodule

// File: rtl/pifo_reg_ctrl.sv
// PIFO controller: slot array, free-slot encoder, registered head and a
// two-state pop sequencer that keeps a stale head from being consumed.
module pifo_reg_ctrl
  import pifo_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ins_vld,
  input  logic [DATA_WIDTH-1:0] ins_rank,
  input  logic [META_WIDTH-1:0] ins_meta,
  output logic                  ins_rdy,
  input  logic                  pop,
  output logic                  pop_rdy,
  output logic                  head_vld,
  output logic [DATA_WIDTH-1:0] head_rank,
  output logic [META_WIDTH-1:0] head_meta,
  output logic [IDX_WIDTH-1:0]  head_idx,
  output logic [IDX_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty
);

  state_e                   state_q, state_d;
  slot_t [REG_WIDTH-1:0]    slots_q, slots_d;
  logic  [IDX_WIDTH:0]      count_q, count_d;
  node_t                    head_q, head_d;
  logic  [META_WIDTH-1:0]   head_meta_q, head_meta_d;

  logic                     free_vld;
  logic  [IDX_WIDTH-1:0]    free_idx;
  node_t [REG_WIDTH-1:0]    leaf;
  node_t                    root;
  logic                     ins_acc, pop_acc;

  assign full    = (count_q == (IDX_WIDTH+1)'(REG_WIDTH));
  assign empty   = (count_q == '0);
  assign ins_rdy = !full;
  assign pop_rdy = (state_q == READY) && head_q.vld;
  assign ins_acc = ins_vld && ins_rdy && free_vld;
  assign pop_acc = pop && pop_rdy;

  assign count     = count_q;
  assign head_vld  = head_q.vld;
  assign head_rank = head_q.rank;
  assign head_idx  = head_q.idx;
  assign head_meta = head_meta_q;

  // Lowest-index free slot, taken from pre-pop state so a slot being popped
  // this cycle is never reused in the same cycle.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = REG_WIDTH - 1; i >= 0; i--) begin
      if (!slots_q[i].vld) begin
        free_vld = 1'b1;
        free_idx = IDX_WIDTH'(i);
      end
    end
  end

  // Tree leaves: each slot tagged with its own index.
  always_comb begin
    for (int i = 0; i < REG_WIDTH; i++) begin
      leaf[i].vld  = slots_q[i].vld;
      leaf[i].rank = slots_q[i].rank;
      leaf[i].idx  = IDX_WIDTH'(i);
    end
  end

  pifo_min_tree #(.N(REG_WIDTH), .LVLS(IDX_WIDTH)) u_tree (
    .leaf (leaf),
    .root (root)
  );

  // Head follows the tree root every cycle; an empty array yields an all-zero head.
  always_comb begin
    head_d      = '0;
    head_meta_d = '0;
    if (root.vld) begin
      head_d      = root;
      head_meta_d = slots_q[root.idx].meta;
    end
  end

  // Slot updates: pop clears the head slot, insert fills the free slot.
  always_comb begin
    slots_d = slots_q;
    if (pop_acc) slots_d[head_q.idx].vld = 1'b0;
    if (ins_acc) begin
      slots_d[free_idx].vld  = 1'b1;
      slots_d[free_idx].rank = ins_rank;
      slots_d[free_idx].meta = ins_meta;
    end
  end

  // Occupancy: a simultaneous insert and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({ins_acc, pop_acc})
      2'b10:   count_d = count_q + (IDX_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (IDX_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer: any accepted op forces a cycle for the head to catch up;
  // further inserts keep it there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      READY:   if (ins_acc || pop_acc) state_d = SETTLE;
      SETTLE:  if (!ins_acc)           state_d = READY;
      default: state_d = READY;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= READY;
      slots_q     <= '0;
      count_q     <= '0;
      head_q      <= '0;
      head_meta_q <= '0;
    end else begin
      state_q     <= state_d;
      slots_q     <= slots_d;
      count_q     <= count_d;
      head_q      <= head_d;
      head_meta_q <= head_meta_d;
    end
  end

endmodule

// File: tb/tb_pifo_reg_ctrl.sv
// Self-checking bench: behavioural slot-array model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pifo_reg_ctrl;
  import pifo_reg_pkg::*;

  localparam int N = REG_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ins_vld;
  logic [DATA_WIDTH-1:0] ins_rank;
  logic [META_WIDTH-1:0] ins_meta;
  logic                  ins_rdy;
  logic                  pop;
  logic                  pop_rdy;
  logic                  head_vld;
  logic [DATA_WIDTH-1:0] head_rank;
  logic [META_WIDTH-1:0] head_meta;
  logic [IDX_WIDTH-1:0]  head_idx;
  logic [IDX_WIDTH:0]    count;
  logic                  full;
  logic                  empty;

  always #5 clk = ~clk;

  pifo_reg_ctrl dut (
    .clk(clk), .rst(rst),
    .ins_vld(ins_vld), .ins_rank(ins_rank), .ins_meta(ins_meta), .ins_rdy(ins_rdy),
    .pop(pop), .pop_rdy(pop_rdy),
    .head_vld(head_vld), .head_rank(head_rank), .head_meta(head_meta), .head_idx(head_idx),
    .count(count), .full(full), .empty(empty)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_ok = 1'b0;
  bit          m_vld  [N];
  int          m_rank [N];
  logic [31:0] m_meta [N];
  int          m_count;
  bit          m_hvld;
  int          m_hrank, m_hidx;
  logic [31:0] m_hmeta;
  bit          m_acc_prev;   // an op was accepted last cycle -> head not yet fresh

  int pop_ranks[$];
  int pop_idxs[$];

  task automatic model_step(input bit r, input bit iv, input int rk, input logic [31:0] mt, input bit pv);
    int  best, fr;
    bit  ins_ok, pop_ok;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_vld[i] = 0; m_rank[i] = 0; m_meta[i] = '0;
      end
      m_count = 0; m_hvld = 0; m_hrank = 0; m_hidx = 0; m_hmeta = '0;
      m_acc_prev = 0; m_ok = 1;
      return;
    end
    best = -1;
    for (int i = 0; i < N; i++)
      if (m_vld[i] && (best < 0 || m_rank[i] < m_rank[best])) best = i;
    fr = -1;
    for (int i = N - 1; i >= 0; i--)
      if (!m_vld[i]) fr = i;
    ins_ok = iv && (m_count < N);
    pop_ok = pv && m_hvld && !m_acc_prev;
    if (pop_ok) m_vld[m_hidx] = 0;
    if (ins_ok) begin
      m_vld[fr] = 1; m_rank[fr] = rk; m_meta[fr] = mt;
    end
    m_count = m_count + (ins_ok ? 1 : 0) - (pop_ok ? 1 : 0);
    if (best >= 0) begin
      m_hvld = 1; m_hrank = m_rank[best]; m_hidx = best; m_hmeta = m_meta[best];
      // the head was sampled before this edge's writes
      if (pop_ok && best == m_hidx) m_hmeta = m_hmeta;
    end else begin
      m_hvld = 0;
    end
    m_acc_prev = ins_ok || pop_ok;
  endtask

  // Head snapshot must precede slot writes; recompute properly.
  task automatic step(input bit r, input bit iv, input int rk, input logic [31:0] mt, input bit pv);
    bit          snap_v;
    int          snap_r, snap_i;
    logic [31:0] snap_m;
    int          best;
    best = -1;
    for (int i = 0; i < N; i++)
      if (m_vld[i] && (best < 0 || m_rank[i] < m_rank[best])) best = i;
    snap_v = (best >= 0);
    snap_r = snap_v ? m_rank[best] : 0;
    snap_i = snap_v ? best : 0;
    snap_m = snap_v ? m_meta[best] : '0;
    model_step(r, iv, rk, mt, pv);
    if (!r) begin
      m_hvld = snap_v; m_hrank = snap_r; m_hidx = snap_i; m_hmeta = snap_m;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_ok) begin
      chk("ins_rdy",  ins_rdy,  (m_count < N));
      chk("pop_rdy",  pop_rdy,  (m_hvld && !m_acc_prev));
      chk("head_vld", head_vld, m_hvld);
      chk("count",    count,    m_count);
      chk("full",     full,     (m_count == N));
      chk("empty",    empty,    (m_count == 0));
      if (m_hvld) begin
        chk("head_rank", head_rank, m_hrank);
        chk("head_idx",  head_idx,  m_hidx);
        chk("head_meta", head_meta, m_hmeta);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input bit r, input bit iv, input int rk, input logic [31:0] mt, input bit pv);
    @(negedge clk);
    #1;
    rst = r; ins_vld = iv; ins_rank = 16'(rk); ins_meta = mt; pop = pv;
    if (pv && pop_rdy && !r) begin
      pop_ranks.push_back(int'(head_rank));
      pop_idxs.push_back(int'(head_idx));
    end
    @(posedge clk);
    step(r, iv, rk, mt, pv);
  endtask

  task automatic idle();
    tick(0, 0, 0, '0, 0);
  endtask

  task automatic ins(input int rk);
    tick(0, 1, rk, $urandom, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && m_count != 0; k++) tick(0, 0, 0, '0, 1);
    idle();
    #2 chk("drain_count", count, 0);
  endtask

  task automatic pad(input int n);
    while (pop_ranks.size() < n) pop_ranks.push_back(-1);
    while (pop_idxs.size() < n)  pop_idxs.push_back(-1);
  endtask

  initial begin
    rst = 1; ins_vld = 0; ins_rank = '0; ins_meta = '0; pop = 0;

    // reset then idle
    tick(1, 0, 0, '0, 0);
    tick(1, 0, 0, '0, 0);
    idle();
    #2;
    chk("rst_head_vld", head_vld, 0);
    chk("rst_count",    count,    0);
    chk("rst_empty",    empty,    1);
    chk("rst_full",     full,     0);
    chk("rst_ins_rdy",  ins_rdy,  1);
    chk("rst_pop_rdy",  pop_rdy,  0);

    // 7, 3, 9 then three spaced pops
    tick(0, 1, 7, 32'h70, 0);
    tick(0, 1, 3, 32'h30, 0);
    tick(0, 1, 9, 32'h90, 0);
    idle(); idle();
    #2;
    chk("t2_head_rank", head_rank, 3);
    chk("t2_head_idx",  head_idx,  1);
    chk("t2_head_meta", head_meta, 32'h30);
    chk("t2_count",     count,     3);
    pop_ranks.delete(); pop_idxs.delete();
    repeat (3) begin tick(0, 0, 0, '0, 1); idle(); end
    pad(3);
    chk("t2_pop0", pop_ranks[0], 3);
    chk("t2_pop1", pop_ranks[1], 7);
    chk("t2_pop2", pop_ranks[2], 9);
    #2 chk("t2_empty", empty, 1);

    // fill to full, held-off insert, one pop
    for (int i = 0; i < N; i++) ins(15 - i);
    #2;
    chk("t3_full",    full,    1);
    chk("t3_ins_rdy", ins_rdy, 0);
    tick(0, 1, 99, 32'hdead, 0);
    #2 chk("t3_held_count", count, 16);
    idle(); idle();
    pop_ranks.delete(); pop_idxs.delete();
    tick(0, 0, 0, '0, 1);
    #2 chk("t3_ins_rdy_back", ins_rdy, 1);
    pad(1);
    chk("t3_pop_rank", pop_ranks[0], 0);
    drain();

    // ties: 5, 5, 2, 5 -> idx 2, 0, 1
    ins(5); ins(5); ins(2); ins(5);
    idle(); idle();
    pop_ranks.delete(); pop_idxs.delete();
    repeat (3) begin tick(0, 0, 0, '0, 1); idle(); end
    pad(3);
    chk("t4_idx0", pop_idxs[0], 2);
    chk("t4_idx1", pop_idxs[1], 0);
    chk("t4_idx2", pop_idxs[2], 1);
    drain();

    // simultaneous insert and pop
    ins(4);
    idle(); idle();
    tick(0, 1, 1, 32'h11, 1);
    #2 chk("t5_count", count, 1);
    idle();
    #2;
    chk("t5_head_rank", head_rank, 1);
    chk("t5_head_idx",  head_idx,  1);
    chk("t5_pop_rdy",   pop_rdy,   1);
    drain();

    // pop during SETTLE is ignored
    ins(2); ins(8);
    idle(); idle();
    tick(0, 0, 0, '0, 1);
    #2 chk("t6_settle_pop_rdy", pop_rdy, 0);
    tick(0, 0, 0, '0, 1);
    #2 chk("t6_count", count, 1);
    drain();

    // reset mid-operation with count 5 in SETTLE
    for (int i = 0; i < 5; i++) ins(10 + i);
    #2;
    chk("t7_count5",  count,   5);
    chk("t7_settle",  pop_rdy, 0);
    tick(1, 0, 0, '0, 0);
    #2;
    chk("t7_rst_count",    count,    0);
    chk("t7_rst_head_vld", head_vld, 0);
    ins(6); idle(); idle();
    #2 chk("t7_ready_again", pop_rdy, 1);
    drain();

    // randomized traffic in fill/drain phases
    for (int ph = 0; ph < 8; ph++) begin
      int pins;
      pins = (ph % 2 == 0) ? 75 : 25;
      for (int k = 0; k < 300; k++) begin
        bit r, iv, pv;
        r  = ($urandom_range(0, 299) == 0);
        iv = ($urandom_range(0, 99) < pins);
        pv = ($urandom_range(0, 99) < 100 - pins);
        tick(r, iv, int'($urandom_range(0, 31)), $urandom, pv);
      end
    end
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
